// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential 32x32 multiply/divide unit with HI/LO result registers.
// Signed operations run on operand magnitudes through a shared unsigned
// datapath (shift-add multiply, restoring divide). Signs are reapplied when
// the result is committed, so one 32-step engine serves all four operations.
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  MDOp,
   input  logic        Start,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   localparam logic [4:0] LAST_STEP = 5'd31;

   state_t      r_state;
   logic [4:0]  r_cnt;       // step counter, 0..31
   logic        r_div;       // 1 = divide, 0 = multiply
   logic [31:0] r_a;         // original dividend, returned as HI on divide by zero
   logic [31:0] r_m;         // multiplicand magnitude or divisor magnitude
   logic [31:0] r_w_hi;      // partial product high half / partial remainder
   logic [31:0] r_w_lo;      // multiplier / dividend shifting into quotient
   logic        r_neg_res;   // negate product or quotient at commit
   logic        r_neg_rem;   // negate remainder at commit (dividend sign)
   logic        r_bz;        // divisor was zero
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_done;

   // Request decode
   logic        w_start_md;
   logic        w_start_mthi;
   logic        w_start_mtlo;
   logic        w_signed;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;

   assign w_start_md   = Start & ~MDOp[2];
   assign w_start_mthi = Start & (MDOp == 3'b100);
   assign w_start_mtlo = Start & (MDOp == 3'b101);
   assign w_signed     = ~MDOp[0];              // MULT and DIV are the signed forms
   assign w_a_neg      = w_signed & A[31];
   assign w_b_neg      = w_signed & B[31];
   assign w_a_mag      = w_a_neg ? (32'd0 - A) : A;
   assign w_b_mag      = w_b_neg ? (32'd0 - B) : B;

   // One multiply step: conditionally add multiplicand, then shift {carry,hi,lo} right
   logic [32:0] w_madd;
   assign w_madd = {1'b0, r_w_hi} + (r_w_lo[0] ? {1'b0, r_m} : 33'd0);

   // One restoring divide step: shift next dividend bit into remainder, trial-subtract
   logic [32:0] w_shift;
   logic        w_ge;
   logic [31:0] w_sub;
   assign w_shift = {r_w_hi, r_w_lo[31]};
   assign w_ge    = (w_shift >= {1'b0, r_m});
   assign w_sub   = w_shift[31:0] - r_m;     // exact when w_ge, since result < divisor

   // Commit values with signs restored
   logic [63:0] w_prod;
   logic [63:0] w_prod_s;
   logic [31:0] w_quot;
   logic [31:0] w_rem;
   assign w_prod   = {r_w_hi, r_w_lo};
   assign w_prod_s = r_neg_res ? (64'd0 - w_prod) : w_prod;
   assign w_quot   = r_neg_res ? (32'd0 - r_w_lo) : r_w_lo;
   assign w_rem    = r_neg_rem ? (32'd0 - r_w_hi) : r_w_hi;

   // Control FSM, datapath registers and HI/LO, all updated on the rising edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= 5'd0;
         r_div     <= 1'b0;
         r_a       <= 32'd0;
         r_m       <= 32'd0;
         r_w_hi    <= 32'd0;
         r_w_lo    <= 32'd0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_bz      <= 1'b0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start_md) begin
                  r_state   <= S_RUN;
                  r_cnt     <= 5'd0;
                  r_div     <= MDOp[1];
                  r_a       <= A;
                  r_m       <= MDOp[1] ? w_b_mag : w_a_mag;
                  r_w_lo    <= MDOp[1] ? w_a_mag : w_b_mag;
                  r_w_hi    <= 32'd0;
                  r_neg_res <= w_a_neg ^ w_b_neg;
                  r_neg_rem <= w_a_neg;
                  r_bz      <= (B == 32'd0);
               end else if (w_start_mthi) begin
                  r_hi <= A;
               end else if (w_start_mtlo) begin
                  r_lo <= A;
               end
            end
            S_RUN: begin
               if (r_div) begin
                  r_w_hi <= w_ge ? w_sub : w_shift[31:0];
                  r_w_lo <= {r_w_lo[30:0], w_ge};
               end else begin
                  r_w_hi <= w_madd[32:1];
                  r_w_lo <= {w_madd[0], r_w_lo[31:1]};
               end
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == LAST_STEP) r_state <= S_FIN;
            end
            S_FIN: begin
               if (!r_div) begin
                  r_hi <= w_prod_s[63:32];
                  r_lo <= w_prod_s[31:0];
               end else if (r_bz) begin
                  r_hi <= r_a;
                  r_lo <= 32'hFFFF_FFFF;
               end else begin
                  r_hi <= w_rem;
                  r_lo <= w_quot;
               end
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign Busy = (r_state != S_IDLE);
   assign Done = r_done;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations checked against an arithmetic reference model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] A, B;
   logic [2:0]  MDOp;
   logic        Start;
   logic        Busy, Done;
   logic [31:0] HI, LO;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   muldiv_unit dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .MDOp(MDOp), .Start(Start),
      .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: results straight from the arithmetic definitions
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
      longint      p;
      logic [63:0] u;
      int          sa, sb;
      sa = a; sb = b;
      hi = exp_hi; lo = exp_lo;
      case (op)
         3'd0: begin p = longint'(sa) * longint'(sb); {hi, lo} = p; end
         3'd1: begin u = {32'd0, a} * {32'd0, b}; {hi, lo} = u; end
         3'd2: begin
            if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = 32'd0; lo = 32'h8000_0000; end
            else begin lo = sa / sb; hi = sa % sb; end
         end
         3'd3: begin
            if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
            else begin lo = a / b; hi = a % b; end
         end
         default: ;
      endcase
   endtask

   // Issue one MULT/DIV at the current negedge and follow it to Done
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit chg, input string name);
      int k, busy_n;
      bit seen, hold_ok;
      logic [31:0] eh, el;
      model(op, a, b, eh, el);
      A = a; B = b; MDOp = op; Start = 1'b1;
      @(posedge clk); #1 Start = 1'b0;
      busy_n = 0; seen = 0; hold_ok = 1;
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         if (Done) begin seen = 1; break; end
         if (Busy) busy_n++;
         if (HI !== exp_hi || LO !== exp_lo) hold_ok = 0;
         if (chg) begin A = $urandom; B = $urandom; MDOp = 3'($urandom_range(0, 7)); end
      end
      checks++;
      if (!seen || k != 33) begin errors++; $display("FAIL %s latency: got %0d cycles (seen=%0d) expected 33", name, k, seen); end
      checks++;
      if (busy_n != 33) begin errors++; $display("FAIL %s busy_len: got %0d expected 33", name, busy_n); end
      checks++;
      if (!hold_ok) begin errors++; $display("FAIL %s hold: HI/LO changed before commit, expected %h/%h", name, exp_hi, exp_lo); end
      checks++;
      if (HI !== eh) begin errors++; $display("FAIL %s HI: got %h expected %h (A=%h B=%h op=%0d)", name, HI, eh, a, b, op); end
      checks++;
      if (LO !== el) begin errors++; $display("FAIL %s LO: got %h expected %h (A=%h B=%h op=%0d)", name, LO, el, a, b, op); end
      exp_hi = eh; exp_lo = el;
   endtask

   task automatic test_reset();
      rst = 1'b1; Start = 1'b0; A = 32'd0; B = 32'd0; MDOp = 3'd0;
      repeat (3) @(negedge clk);
      checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_HI: got %h expected 0", HI); end
      checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_LO: got %h expected 0", LO); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_Busy: got %b expected 0", Busy); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_Done: got %b expected 0", Done); end
      rst = 1'b0;
      exp_hi = 32'd0; exp_lo = 32'd0;
   endtask

   task automatic test_directed();
      run_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 0, "mult_neg3x5");
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
      run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0, "div_neg7by2");
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_overflow");
      run_op(3'd3, 32'h0000_0007, 32'h0000_0000, 0, "divu_by0");
      run_op(3'd2, 32'hFFFF_FFF0, 32'h0000_0000, 0, "div_by0");
   endtask

   task automatic test_mthi_mtlo();
      Start = 1'b1; MDOp = 3'b100; A = 32'h1234_5678;
      @(negedge clk);
      MDOp = 3'b101; A = 32'h9ABC_DEF0;
      checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mthi_HI: got %h expected 12345678", HI); end
      checks++; if (LO !== exp_lo) begin errors++; $display("FAIL mthi_LO: got %h expected %h", LO, exp_lo); end
      checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL mthi_flags: got Busy=%b Done=%b expected 0/0", Busy, Done); end
      @(negedge clk);
      Start = 1'b0;
      checks++; if (LO !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo_LO: got %h expected 9abcdef0", LO); end
      checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_HI: got %h expected 12345678", HI); end
      checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL mtlo_flags: got Busy=%b Done=%b expected 0/0", Busy, Done); end
      exp_hi = 32'h1234_5678; exp_lo = 32'h9ABC_DEF0;
      run_op(3'd1, 32'h0001_2345, 32'h00AB_CDEF, 1, "multu_latched");
   endtask

   task automatic test_noop();
      Start = 1'b1; MDOp = 3'b110; A = 32'hDEAD_BEEF; B = 32'h1;
      @(negedge clk);
      MDOp = 3'b111;
      @(negedge clk);
      Start = 1'b0;
      checks++; if (HI !== exp_hi || LO !== exp_lo) begin errors++; $display("FAIL noop_hilo: got %h/%h expected %h/%h", HI, LO, exp_hi, exp_lo); end
      checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL noop_flags: got Busy=%b Done=%b expected 0/0", Busy, Done); end
   endtask

   task automatic test_interrupt();
      bit done_seen;
      A = 32'h0000_1000; B = 32'h0000_0003; MDOp = 3'd3; Start = 1'b1;
      @(posedge clk); #1 Start = 1'b0;
      done_seen = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (Done) done_seen = 1;
         if (c == 10) begin Start = 1'b1; MDOp = 3'b100; A = 32'hCAFE_F00D; end
         if (c == 11) begin
            Start = 1'b0;
            checks++; if (Busy !== 1'b1 || HI !== exp_hi) begin errors++; $display("FAIL busy_ignore: got Busy=%b HI=%h expected 1/%h", Busy, HI, exp_hi); end
         end
         if (c == 20) rst = 1'b1;
         if (c == 21) begin
            rst = 1'b0;
            checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_Busy: got %b expected 0", Busy); end
            checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL abort_hilo: got %h/%h expected 0/0", HI, LO); end
         end
      end
      checks++; if (done_seen) begin errors++; $display("FAIL abort_done: got Done pulse expected none"); end
      exp_hi = 32'd0; exp_lo = 32'd0;
      run_op(3'd1, 32'h89AB_CDEF, 32'h0000_1234, 0, "multu_after_rst");
   endtask

   // Random operations issued back-to-back in the Done cycle
   task automatic test_back_to_back();
      logic [31:0] a, b;
      logic [2:0]  op;
      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(0, 3));
         a = $urandom; b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 17));
            3: b = 32'd0 - 32'($urandom_range(1, 17));
            default: ;
         endcase
         run_op(op, a, b, bit'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      rst = 1'b1; Start = 1'b0; A = 32'd0; B = 32'd0; MDOp = 3'd0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_mthi_mtlo();
      test_noop();
      test_interrupt();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port A, input, 32 bits: operand 1 (dividend, multiplicand, or MTHI/MTLO data).
REQ-004 SHALL have port B, input, 32 bits: operand 2 (divisor, multiplier).
REQ-005 SHALL have port MDOp, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-op.
REQ-006 SHALL have port Start, input, 1 bit: request, sampled only when Busy=0.
REQ-007 SHALL have port Busy, output, 1 bit: multi-cycle operation in progress.
REQ-008 SHALL have port Done, output, 1 bit: one-cycle pulse when HI/LO take a MULT/DIV result.
REQ-009 SHALL have port HI, output, 32 bits: HI register, registered.
REQ-010 SHALL have port LO, output, 32 bits: LO register, registered.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and FIN; Busy SHALL be 1 exactly in RUN and FIN.
REQ-012 SHALL, in IDLE with Start=1 and MDOp in {MULT, MULTU, DIV, DIVU} at edge E0, latch A, B and MDOp, clear the step counter, and enter RUN.
REQ-013 SHALL make the operation result independent of A, B and MDOp changes after E0.
REQ-014 SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per edge in RUN, 32 steps total (edges E1..E32), then enter FIN.
REQ-015 SHALL, at edge E33 (FIN), write HI/LO, assert Done for the following cycle only, and return to IDLE; the fixed latency from start edge to result visible is 33 cycles.
REQ-016 SHALL, for MULT, compute the signed 64-bit product of A and B, with HI = bits 63:32 and LO = bits 31:0.
REQ-017 SHALL, for MULTU, compute the unsigned 64-bit product in the same HI/LO layout.
REQ-018 SHALL, for DIVU, set LO = unsigned quotient and HI = unsigned remainder.
REQ-019 SHALL, for DIV, truncate the quotient toward zero, give the remainder the dividend's sign, and keep the magnitude identity A = LO*B + HI.
REQ-020 SHALL, for divide by zero (DIV or DIVU, B=0), set LO=FFFFFFFF and HI=A.
REQ-021 SHALL, for DIV with A=80000000 and B=FFFFFFFF, set LO=80000000 and HI=00000000.
REQ-022 SHALL, in IDLE with Start=1 and MTHI, write HI=A at that edge; LO, Busy and Done SHALL be unaffected.
REQ-023 SHALL handle MTLO the same way as MTHI, but for LO.
REQ-024 SHALL ignore Start while Busy=1, with no state, HI or LO change.
REQ-025 SHALL treat Start with MDOp 110 or 111 as a no-op.
REQ-026 SHALL accept a new Start in the cycle Done=1 (state IDLE), enabling back-to-back operation every 34 cycles.
REQ-027 SHALL leave HI/LO unchanged during RUN and FIN; the previous values stay readable until E33.

Reset
REQ-028 SHALL, when rst=1 at an edge, force state to IDLE, HI=0, LO=0, Busy=0, Done=0, and clear all internal registers.
REQ-029 SHALL give rst priority over Start and over any in-flight step; an operation interrupted by reset produces no Done and no HI/LO write.
REQ-030 SHALL, on the first edge after rst deasserts, accept Start normally.

Verification
REQ-031 SHALL cover: MULT, A=FFFFFFFD (-3), B=00000005 -> after 33 cycles Done=1, HI=FFFFFFFF, LO=FFFFFFF1; Busy=1 for exactly 33 cycles.
REQ-032 SHALL cover: MULTU, A=B=FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
REQ-033 SHALL cover: DIV, A=FFFFFFF9 (-7), B=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF; then DIV, A=80000000, B=FFFFFFFF -> LO=80000000, HI=00000000.
REQ-034 SHALL cover: DIVU, A=00000007, B=00000000 -> LO=FFFFFFFF, HI=00000007.
REQ-035 SHALL cover: MTHI A=12345678, then MTLO A=9ABCDEF0 on consecutive cycles -> HI=12345678, LO=9ABCDEF0, Busy and Done stay 0; then Start MULTU with B changing every cycle during RUN -> result uses the values latched at E0.
REQ-036 SHALL cover: Start DIVU, a second Start at cycle 10 (ignored), rst at cycle 20 -> Busy=0, HI=LO=0, no Done; a new MULTU Start after reset completes correctly.
